// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state codes, defaults, clog2.
package arb_pkg;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;
  localparam int unsigned HOLD_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } arb_state_e;

  // Ceiling log2, used for index widths (valid for v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_fsm_if.sv
// Request/grant bundle between bus masters and the arbiter.
interface rr_arbiter_fsm_if
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
);
  localparam int unsigned IDW = clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output gnt_valid,
    output gnt_id
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first unmasked request at or after start.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  start,
  output logic [NREQ-1:0] pick_oh_c,
  output logic [IDW-1:0]  pick_id_c,
  output logic            any_c
);

  logic [NREQ-1:0] eff_req;

  assign eff_req = req & ~mask;

  // Scan from start upward with wrap; first hit wins.
  always_comb begin
    logic [IDW-1:0] idx;
    pick_oh_c = '0;
    pick_id_c = '0;
    any_c     = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IDW'((32'(start) + off) % NREQ);
      if (!any_c && eff_req[idx]) begin
        any_c          = 1'b1;
        pick_oh_c[idx] = 1'b1;
        pick_id_c      = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// N-way round-robin arbiter with bounded hold time and registered grant.
// Optional build macro ARB_LOCK_EN: the granted requester's lock bit freezes
// the hold counter so atomic multi-beat transfers are not preempted.
module rr_arbiter_fsm
  import arb_pkg::*;
#(
  parameter  int unsigned NREQ     = DEF_NREQ,
  parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned IDW      = clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  rr_arbiter_fsm_if.slave   bus
);

  localparam logic [IDW-1:0]    LAST_RST = IDW'(NREQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              valid_q, valid_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [IDW-1:0]    start_c;
  logic [NREQ-1:0]   pick_oh_c;
  logic [IDW-1:0]    pick_id_c;
  logic              pick_any_c;
  logic              cur_req_c;
  logic              others_c;
  logic              locked_c;

  // Search begins one past the most recently granted requester.
  assign start_c   = (last_q == LAST_RST) ? '0 : last_q + IDW'(1);
  assign cur_req_c = |(bus.req & gnt_q);
  assign others_c  = |(bus.req & ~gnt_q);

`ifdef ARB_LOCK_EN
  // Lock only counts for the requester currently holding the grant.
  assign locked_c = |(bus.lock & gnt_q) && cur_req_c;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign locked_c    = 1'b0;
`endif

  // Masking the current holder makes a timeout rotate away from it.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (bus.req),
    .mask      (gnt_q),
    .start     (start_c),
    .pick_oh_c (pick_oh_c),
    .pick_id_c (pick_id_c),
    .any_c     (pick_any_c)
  );

  // State, grant outputs and bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, next-grant and hold-counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d = GRANT;
          gnt_d   = pick_oh_c;
          id_d    = pick_id_c;
          last_d  = pick_id_c;
          hold_d  = '0;
        end
      end

      GRANT: begin
        if (!cur_req_c) begin
          if (others_c) begin
            // Holder released: hand over directly, no idle bubble.
            gnt_d  = pick_oh_c;
            id_d   = pick_id_c;
            last_d = pick_id_c;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (locked_c) begin
          hold_d = hold_q;
        end else if (!others_c) begin
          // Sole requester: keep grant, counter saturates.
          if (hold_q < HOLD_TOP) hold_d = hold_q + HOLD_W'(1);
        end else if (hold_q < HOLD_TOP) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          // Hold budget spent with others waiting: rotate.
          gnt_d  = pick_oh_c;
          id_d   = pick_id_c;
          last_d = pick_id_c;
          hold_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase

    valid_d = |gnt_d;
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed testbench for rr_arbiter_fsm (NREQ=4, MAX_HOLD=8).
module tb_rr_arbiter_fsm;
  import arb_pkg::*;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned total = 0;
  int unsigned bad   = 0;

  rr_arbiter_fsm_if #(.NREQ(NREQ)) bus ();

  rr_arbiter_fsm #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check the one-hot invariant.
  task automatic step();
    @(posedge clock);
    #1;
    check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
  endtask

  task automatic expect_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(g != 4'b0000));
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = 'x;
    bus.lock = '0;

    // Reset holds everything idle regardless of req.
    step();
    expect_gnt("rst0", 4'b0000, 2'd0);
    bus.req = 4'b1111;
    step();
    expect_gnt("rst1", 4'b0000, 2'd0);

    // First edge after release grants requester 0.
    reset = 1'b0;
    step();
    expect_gnt("first", 4'b0001, 2'd0);

    // Round robin: 0,1,2,3,0 each for exactly MAX_HOLD cycles.
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        expect_gnt("rr", 4'(1 << (k % 4)), 2'(k % 4));
        step();
      end
    end
    expect_gnt("rr_next", 4'b0010, 2'd1);

    // Early release by holder 1 hands straight to 2, then idle.
    bus.req = 4'b1100;
    step();
    expect_gnt("early", 4'b0100, 2'd2);
    bus.req = 4'b0000;
    step();
    expect_gnt("idle0", 4'b0000, 2'd0);

    // Sole requester keeps the grant; counter saturates, not wraps.
    bus.req = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      step();
      expect_gnt("sole", 4'b0010, 2'd1);
    end
    bus.req = 4'b0011;
    step();
    expect_gnt("sat_rot", 4'b0001, 2'd0);
    bus.req = 4'b0000;
    step();
    expect_gnt("idle1", 4'b0000, 2'd0);

    // Wrap: last=3 so search restarts at 0.
    bus.req = 4'b1000;
    step();
    expect_gnt("g3", 4'b1000, 2'd3);
    bus.req = 4'b0000;
    step();
    expect_gnt("idle2", 4'b0000, 2'd0);
    bus.req = 4'b1001;
    step();
    expect_gnt("wrap", 4'b0001, 2'd0);
    bus.req = 4'b1000;
    step();
    expect_gnt("handoff", 4'b1000, 2'd3);

    // Reset mid-grant drops gnt on the next edge.
    reset = 1'b1;
    step();
    expect_gnt("rst_mid", 4'b0000, 2'd0);
    reset   = 1'b0;
    bus.req = 4'b0000;
    step();
    expect_gnt("idle3", 4'b0000, 2'd0);

    // After reset last=3: simultaneous 1 and 2 resolve to 1.
    bus.req = 4'b0110;
    step();
    expect_gnt("simul", 4'b0010, 2'd1);
    bus.req = 4'b0000;
    step();
    expect_gnt("idle4", 4'b0000, 2'd0);

    // Grant 2, then three cycles of contention (hold reaches 3).
    bus.req = 4'b0100;
    step();
    expect_gnt("g2", 4'b0100, 2'd2);
    bus.req = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_gnt("g2_hold", 4'b0100, 2'd2);
    end

`ifdef ARB_LOCK_EN
    // Lock freezes the counter: no rotation however long others wait.
    bus.lock = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_gnt("locked", 4'b0100, 2'd2);
    end
    bus.lock = 4'b0000;
`else
    // Lock is ignored in this build.
    bus.lock = 4'b0100;
`endif

    // Remaining budget from hold=3: four more cycles, then rotate to 0.
    for (int i = 0; i < 4; i++) begin
      step();
      expect_gnt("budget", 4'b0100, 2'd2);
    end
    step();
    expect_gnt("rot0", 4'b0001, 2'd0);

    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step();
    expect_gnt("idle5", 4'b0000, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
